// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR file.
//   - CSR addresses, mstatus/mip bit indices, privilege encodings
//   - MRET instruction encoding
//   - trap FSM state type
//   - address classification helpers used by the decode read port
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  localparam logic [31:0] MRET_INSN = 32'h3020_0073;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_REDIRECT
  } trap_state_t;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
      CSR_MHARTID: csr_implemented = 1'b1;
      default:     csr_implemented = 1'b0;
    endcase
  endfunction

  function automatic logic csr_read_only(input logic [11:0] addr);
    case (addr)
      CSR_MISA, CSR_MIP, CSR_MHARTID: csr_read_only = 1'b1;
      default:                        csr_read_only = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_fsm.sv
// csr_trap_fsm: trap-entry / MRET sequencer for csr_file.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cs                : context-switch request (accepted only in IDLE)
//   mret              : MRET commit (ignored if cs is also set)
//   mtvec, mepc       : current trap vector and exception PC
//   pc, cause, tval   : trap information, latched on acceptance
//   idle, save        : state decode used by the register file
//   trap_pc/cause/tval: latched trap information, valid during SAVE
//   pc_mux, target    : registered fetch redirect and its target
//   busy              : registered pipeline stall during SAVE/REDIRECT
module csr_trap_fsm
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs,
  input  logic            mret,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] cause,
  input  logic [XLEN-1:0] tval,
  output logic            idle,
  output logic            save,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_tval,
  output logic            pc_mux,
  output logic [XLEN-1:0] target,
  output logic            busy
);

  trap_state_t     state;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] vec_target;

  assign idle = (state == ST_IDLE);
  assign save = (state == ST_SAVE);

  // Vectored mode only applies to interrupts; exceptions always use the base.
  assign base       = mtvec & ~XLEN'(3);
  assign vec_target = (mtvec[0] && trap_cause[XLEN-1])
                    ? base + (XLEN'(trap_cause[5:0]) << 2)
                    : base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc_mux     <= 1'b0;
      busy       <= 1'b0;
      target     <= '0;
      trap_pc    <= '0;
      trap_cause <= '0;
      trap_tval  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pc_mux <= 1'b0;
          if (cs) begin
            state      <= ST_SAVE;
            busy       <= 1'b1;
            trap_pc    <= pc;
            trap_cause <= cause;
            trap_tval  <= tval;
          end else if (mret) begin
            pc_mux <= 1'b1;
            target <= mepc;
          end
        end
        ST_SAVE: begin
          state  <= ST_REDIRECT;
          busy   <= 1'b1;
          pc_mux <= 1'b1;
          target <= vec_target;
        end
        ST_REDIRECT: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          pc_mux <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          pc_mux <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file at the end of the writeback stage.
//   CLK, RESET         : clock, asynchronous active-low reset
//   WB_ST_CSR, WB_CSR_DATA, WB_IR_OUT : CSR write commit (address = IR[31:20]),
//                        or MRET when IR matches the MRET encoding
//   WB_PC, WB_CAUSE, WB_TVAL, WB_CS   : trap request and its information
//   WB_RETIRE          : minstret increment
//   TIMER, EXTERNAL    : interrupt lines mirrored into mip
//   DE_CSR_ADDR/RDATA/ILLEGAL : combinational decode read port
//   CSR_PC_MUX, CSR_TARGET, CSR_BUSY : fetch redirect and pipeline stall
//   INT_PENDING, PRIVILEGE : interrupt and privilege status to the trap logic
module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = XLEN'(64'h0000_0000_0000_0100),
  parameter int unsigned     HART_ID     = 0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            WB_ST_CSR,
  input  logic [XLEN-1:0] WB_CSR_DATA,
  input  logic [31:0]     WB_IR_OUT,
  input  logic [XLEN-1:0] WB_PC,
  input  logic            WB_RETIRE,
  input  logic            WB_CS,
  input  logic [XLEN-1:0] WB_CAUSE,
  input  logic [XLEN-1:0] WB_TVAL,
  input  logic            TIMER,
  input  logic            EXTERNAL,
  input  logic [11:0]     DE_CSR_ADDR,
  output logic [XLEN-1:0] DE_CSR_RDATA,
  output logic            DE_CSR_ILLEGAL,
  output logic            CSR_PC_MUX,
  output logic [XLEN-1:0] CSR_TARGET,
  output logic            CSR_BUSY,
  output logic            INT_PENDING,
  output logic [1:0]      PRIVILEGE
);

  localparam logic [XLEN-1:0] ONE           = XLEN'(1);
  localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(64'h1888);
  localparam logic [XLEN-1:0] MIE_WMASK     = XLEN'(64'h0880);
  localparam logic [XLEN-1:0] MTVEC_WMASK   = ~XLEN'(2);
  localparam logic [XLEN-1:0] MEPC_WMASK    = ~XLEN'(3);
  localparam logic [XLEN-1:0] MISA_VAL      = (XLEN'(2) << (XLEN - 2)) | (XLEN'(1) << 8);

  logic [XLEN-1:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval;
  logic [XLEN-1:0] mcycle, minstret, mip;
  logic [1:0]      privilege;

  logic [11:0]     wr_addr;
  logic            mret, mret_take, wr_en;
  logic            fsm_idle, fsm_save;
  logic [XLEN-1:0] trap_pc, trap_cause, trap_tval;

  assign wr_addr   = WB_IR_OUT[31:20];
  assign mret      = (WB_IR_OUT == MRET_INSN) && !WB_ST_CSR;
  // A trap request beats both MRET and a CSR write in the same cycle.
  assign mret_take = fsm_idle && !WB_CS && mret;
  assign wr_en     = fsm_idle && !WB_CS && WB_ST_CSR;

  csr_trap_fsm #(.XLEN(XLEN)) u_trap_fsm (
    .clk        (CLK),
    .rst_n      (RESET),
    .cs         (WB_CS),
    .mret       (mret),
    .mtvec      (mtvec),
    .mepc       (mepc),
    .pc         (WB_PC),
    .cause      (WB_CAUSE),
    .tval       (WB_TVAL),
    .idle       (fsm_idle),
    .save       (fsm_save),
    .trap_pc    (trap_pc),
    .trap_cause (trap_cause),
    .trap_tval  (trap_tval),
    .pc_mux     (CSR_PC_MUX),
    .target     (CSR_TARGET),
    .busy       (CSR_BUSY)
  );

  always_comb begin
    mip           = '0;
    mip[MIP_MTIP] = TIMER;
    mip[MIP_MEIP] = EXTERNAL;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mstatus   <= '0;
      mie       <= '0;
      mtvec     <= MTVEC_RESET & MTVEC_WMASK;
      mscratch  <= '0;
      mepc      <= '0;
      mcause    <= '0;
      mtval     <= '0;
      mcycle    <= '0;
      minstret  <= '0;
      privilege <= PRIV_M;
    end else begin
      // Counter increments first so a same-cycle CSR write below overrides them.
      mcycle <= mcycle + ONE;
      if (WB_RETIRE) minstret <= minstret + ONE;

      if (fsm_save) begin
        mepc   <= trap_pc & MEPC_WMASK;
        mcause <= trap_cause;
        mtval  <= trap_tval;
        mstatus[MSTATUS_MPIE]                  <= mstatus[MSTATUS_MIE];
        mstatus[MSTATUS_MIE]                   <= 1'b0;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= privilege;
        privilege <= PRIV_M;
      end else if (mret_take) begin
        mstatus[MSTATUS_MIE]                   <= mstatus[MSTATUS_MPIE];
        mstatus[MSTATUS_MPIE]                  <= 1'b1;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= PRIV_U;
        privilege <= mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
      end else if (wr_en) begin
        case (wr_addr)
          CSR_MSTATUS:  mstatus  <= WB_CSR_DATA & MSTATUS_WMASK;
          CSR_MIE:      mie      <= WB_CSR_DATA & MIE_WMASK;
          CSR_MTVEC:    mtvec    <= WB_CSR_DATA & MTVEC_WMASK;
          CSR_MSCRATCH: mscratch <= WB_CSR_DATA;
          CSR_MEPC:     mepc     <= WB_CSR_DATA & MEPC_WMASK;
          CSR_MCAUSE:   mcause   <= WB_CSR_DATA;
          CSR_MTVAL:    mtval    <= WB_CSR_DATA;
          CSR_MCYCLE:   mcycle   <= WB_CSR_DATA;
          CSR_MINSTRET: minstret <= WB_CSR_DATA;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    DE_CSR_RDATA = '0;
    case (DE_CSR_ADDR)
      CSR_MSTATUS:  DE_CSR_RDATA = mstatus;
      CSR_MISA:     DE_CSR_RDATA = MISA_VAL;
      CSR_MIE:      DE_CSR_RDATA = mie;
      CSR_MTVEC:    DE_CSR_RDATA = mtvec;
      CSR_MSCRATCH: DE_CSR_RDATA = mscratch;
      CSR_MEPC:     DE_CSR_RDATA = mepc;
      CSR_MCAUSE:   DE_CSR_RDATA = mcause;
      CSR_MTVAL:    DE_CSR_RDATA = mtval;
      CSR_MIP:      DE_CSR_RDATA = mip;
      CSR_MCYCLE:   DE_CSR_RDATA = mcycle;
      CSR_MINSTRET: DE_CSR_RDATA = minstret;
      CSR_MHARTID:  DE_CSR_RDATA = XLEN'(HART_ID);
      default:      DE_CSR_RDATA = '0;
    endcase
  end

  // The decode port carries no write intent, so the read-only half of the
  // check looks at the write being committed by writeback this cycle.
  assign DE_CSR_ILLEGAL = !csr_implemented(DE_CSR_ADDR)
                        || (WB_ST_CSR && csr_read_only(wr_addr));

  assign INT_PENDING = mstatus[MSTATUS_MIE] && |(mie & mip);
  assign PRIVILEGE   = privilege;

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode Control/Status Register file: receiving end of the writeback stage's CSR-store and trap outputs.
- Commits CSR instruction writes and performs the hardware trap-entry sequence when writeback signals a context switch. The sequence saves mepc, mcause and mstatus, then redirects fetch to mtvec.
- Handles MRET return, keeps the mcycle/minstret counters, provides a combinational read port to decode, and reports pending-interrupt and privilege state back to the trap logic.

Parameters:
- XLEN, 64, data width of every CSR.
- MTVEC_RESET, 64'h0000_0000_0000_0100, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.

Ports:
- CLK  in  1  core clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- WB_ST_CSR  in  1  commit a CSR write this cycle.
- WB_CSR_DATA  in  64  CSR write data.
- WB_IR_OUT  in  32  committed instruction; CSR address = [31:20]; MRET = 32'h3020_0073.
- WB_PC  in  64  PC of the committed or faulting instruction.
- WB_RETIRE  in  1  instruction retired (valid and not trapped).
- WB_CS  in  1  context-switch request from the trap handler.
- WB_CAUSE  in  64  mcause value; bit 63 = interrupt.
- WB_TVAL  in  64  faulting address/instruction, or 0.
- TIMER  in  1  machine timer interrupt line, mirrored into mip.MTIP.
- EXTERNAL  in  1  machine external interrupt line, mirrored into mip.MEIP.
- DE_CSR_ADDR  in  12  decode read address.
- DE_CSR_RDATA  out  64  combinational read data.
- DE_CSR_ILLEGAL  out  1  DE_CSR_ADDR is unimplemented, or a write targets a read-only CSR.
- CSR_PC_MUX  out  1  one-cycle fetch redirect.
- CSR_TARGET  out  64  redirect target.
- CSR_BUSY  out  1  stall the pipeline while the trap FSM is active.
- INT_PENDING  out  1  mstatus.MIE & |(mie & mip).
- PRIVILEGE  out  2  current privilege level: 2'b11 = M, 2'b00 = U.

Behaviour:
- Reset values (RESET low, asynchronous):
  - mstatus = 0; mie = 0; mscratch/mepc/mcause/mtval = 0; mcycle = minstret = 0.
  - mtvec = MTIVEC_RESET; PRIVILEGE = 2'b11; FSM = IDLE.
  - CSR_PC_MUX = 0; CSR_BUSY = 0; CSR_TARGET = 0.
- Implemented CSRs:
  - mstatus 0x300: only MIE[3], MPIE[7] and MPP[12:11] are writable; other bits read 0.
  - misa 0x301: read-only, RV64I.
  - mie 0x304: bits 7 and 11 writable.
  - mtvec 0x305: bit 1 reads 0.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only; MTIP = TIMER, MEIP = EXTERNAL.
  - mcycle 0xB00.
  - minstret 0xB02.
  - mhartid 0xF14: read-only, returns HART_ID.
- Unimplemented addresses read 0; writes to them are ignored.
- Read port:
  - DE_CSR_RDATA is purely combinational from the current register state.
  - No bypass of a same-cycle write; decode stalls for that hazard.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when WB_RETIRE = 1.
  - A CSR write to either counter takes priority over its increment in that cycle.
  - Counters wrap modulo 2^64.
- Trap FSM states are IDLE, SAVE and REDIRECT.
- IDLE:
  - WB_CS = 1 moves to SAVE and latches WB_PC, WB_CAUSE and WB_TVAL.
  - MRET with WB_ST_CSR = 0 applies the MRET update (see "MRET"), pulses CSR_PC_MUX with CSR_TARGET = mepc, and stays in IDLE.
- SAVE (one cycle):
  - Writes mepc = PC & ~3, mcause and mtval.
  - Updates mstatus: MPIE = MIE, MIE = 0, MPP = PRIVILEGE.
  - Sets PRIVILEGE = 2'b11.
  - CSR_BUSY = 1. Moves to REDIRECT.
- REDIRECT (one cycle):
  - CSR_PC_MUX = 1, CSR_BUSY = 1.
  - Target when mtvec[0] = 1 and cause[63] = 1 (vectored interrupt): {mtvec[63:2], 2'b00} + 4*cause[5:0].
  - Target otherwise: {mtvec[63:2], 2'b00}.
  - Returns to IDLE.
- MRET:
  - Updates mstatus: MIE = MPIE, MPIE = 1, MPP = 2'b00.
  - Sets PRIVILEGE to the old MPP.
- Priority and boundary conditions:
  - WB_CS and WB_ST_CSR in the same cycle: the trap wins and the CSR write is dropped.
  - WB_CS while not in IDLE: ignored, because the pipeline is stalled by CSR_BUSY.
  - WB_CS and MRET in the same cycle: the trap wins.
  - RESET asserted mid-sequence: immediate return to IDLE and all CSRs to their reset values; no partial redirect is produced.
- Trap-to-redirect latency is 2 cycles after the WB_CS edge.
- INT_PENDING is combinational.

Decomposition:
- Shared package (csr_pkg) holds:
  - CSR address constants.
  - mstatus bit-index constants.
  - Privilege encodings.
  - The MRET encoding.
  - The FSM state typedef.
- One natural sub-module: csr_trap_fsm, containing the IDLE/SAVE/REDIRECT sequencing and the target computation.

Test Plan:
- Reset:
  - Drive RESET low, then release.
  - Read mtvec → 0x100; PRIVILEGE = 2'b11.
  - Read mcycle → counts 1, 2, 3 on successive cycles.
- CSR write/read:
  - WB_ST_CSR with address 0x340 and data 0xDEAD_BEEF.
  - Next cycle, DE_CSR_ADDR = 0x340 → DE_CSR_RDATA = 0xDEAD_BEEF.
  - Write to 0xF14 → mhartid still reads 0 and DE_CSR_ILLEGAL = 1.
- Exception entry:
  - Setup: mstatus.MIE = 1, PRIVILEGE = U.
  - Stimulus: WB_CS with cause 2 and PC 0x8000_0006.
  - Two cycles later: CSR_PC_MUX = 1 with target 0x100.
  - Resulting state: mepc = 0x8000_0004, mcause = 2, MPIE = 1, MIE = 0, MPP = 00, PRIVILEGE = M.
- Vectored interrupt:
  - Setup: mtvec = 0x201.
  - Stimulus: WB_CAUSE = 0x8000_0000_0000_0007.
  - Required: CSR_TARGET = 0x21C.
- MRET:
  - Setup: mepc = 0x4000, MPIE = 1, MPP = 00.
  - Stimulus: MRET commit.
  - Required: CSR_PC_MUX pulses with target 0x4000; MIE = 1; PRIVILEGE = 00.
- Collisions:
  - WB_CS and WB_ST_CSR in the same cycle → mscratch unchanged and the trap is taken.
  - RESET asserted during SAVE → no CSR_PC_MUX pulse and all CSRs back to their reset values.
